// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory responder.
//   - RISC-V load/store funct3 encodings
//   - responder FSM state encoding
//   - byte-lane mask constants (before shifting to the addressed lane)
package dmem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_ACCESS,
      ST_RESP
   } state_t;

   localparam logic [3:0] LANE_B = 4'b0001;
   localparam logic [3:0] LANE_H = 4'b0011;
   localparam logic [3:0] LANE_W = 4'b1111;

endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: load/store port between the core's MEM stage and the
// data-memory responder.
//   request  : req_valid/req_ready handshake, req_we, req_addr (byte address),
//              req_wdata (right-aligned store data), req_funct3
//   response : rsp_valid/rsp_ready handshake, rsp_rdata, rsp_err
// modport master = core side, modport slave = responder side.
interface dmem_responder_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [2:0]  req_funct3;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );

endinterface

// File: rtl/dmem_load_align.sv
// dmem_load_align: combinational lane logic for one 32-bit memory word.
//   word      in  32  word read from the array
//   addr_lo   in  2   byte offset within the word
//   funct3    in  3   access width / signedness
//   rdata     out 32  selected byte/half/word, sign- or zero-extended
//   lane_mask out 4   byte lanes touched by this access (used for store merge)
// Unsupported funct3 values give rdata=0 and an empty mask.
module dmem_load_align
   import dmem_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  funct3,
   output logic [31:0] rdata,
   output logic [3:0]  lane_mask
);

   logic [7:0]  lanes [4];
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lanes[gi] = word[8*gi +: 8];
   end

   assign byte_sel = lanes[addr_lo];
   assign half_sel = addr_lo[1] ? word[31:16] : word[15:0];

   always_comb begin
      rdata     = '0;
      lane_mask = '0;
      case (funct3)
         F3_B: begin
            rdata     = {{24{byte_sel[7]}}, byte_sel};
            lane_mask = LANE_B << addr_lo;
         end
         F3_BU: begin
            rdata     = {24'b0, byte_sel};
            lane_mask = LANE_B << addr_lo;
         end
         F3_H: begin
            rdata     = {{16{half_sel[15]}}, half_sel};
            lane_mask = LANE_H << {addr_lo[1], 1'b0};
         end
         F3_HU: begin
            rdata     = {16'b0, half_sel};
            lane_mask = LANE_H << {addr_lo[1], 1'b0};
         end
         F3_W: begin
            rdata     = word;
            lane_mask = LANE_W;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory slave for the core's load/store port.
//   clk  in   system clock, rising edge
//   rst  in   synchronous active-high reset (array contents are kept)
//   bus  slave modport of dmem_responder_if (request + response channels)
// One request outstanding. After acceptance the FSM spends WAIT_STATES cycles
// in WAIT, one ACCESS cycle (error check, array write, response capture), then
// holds the response in RESP until rsp_ready.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_STATES = 2
) (
   input logic             clk,
   input logic             rst,
   dmem_responder_if.slave bus
);

   localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   state_t      state_reg;
   logic [3:0]  cnt_reg;
   logic        we_reg;
   logic [31:0] addr_reg;
   logic [31:0] wdata_reg;
   logic [2:0]  f3_reg;
   logic        req_ready_reg;
   logic        rsp_valid_reg;
   logic [31:0] rsp_rdata_reg;
   logic        rsp_err_reg;

   logic [31:0] mem [DEPTH_WORDS];
   logic [31:0] rd_word_reg;
   logic [IDX_W-1:0] rd_idx;
   logic [31:0] load_data;
   logic [3:0]  lane_mask;
   logic [31:0] wdata_rep;
   logic [31:0] merged_word;
   logic        access_err;

   // Gating with rst keeps req_ready low for the whole reset pulse.
   assign bus.req_ready = req_ready_reg & ~rst;
   assign bus.rsp_valid = rsp_valid_reg;
   assign bus.rsp_rdata = rsp_rdata_reg;
   assign bus.rsp_err   = rsp_err_reg;

   // The read is launched at the accepting edge using the incoming address,
   // so the word is already registered when ACCESS begins, even with zero
   // wait states. Afterwards the latched address keeps it refreshed.
   assign rd_idx = (state_reg == ST_IDLE) ? bus.req_addr[IDX_W+1:2] : addr_reg[IDX_W+1:2];

   always_ff @(posedge clk) begin
      rd_word_reg <= mem[rd_idx];
   end

   dmem_load_align u_align (
      .word      (rd_word_reg),
      .addr_lo   (addr_reg[1:0]),
      .funct3    (f3_reg),
      .rdata     (load_data),
      .lane_mask (lane_mask)
   );

   // Replicate the right-aligned store data to every lane it could land in.
   always_comb begin
      case (f3_reg[1:0])
         2'b00:   wdata_rep = {4{wdata_reg[7:0]}};
         2'b01:   wdata_rep = {2{wdata_reg[15:0]}};
         default: wdata_rep = wdata_reg;
      endcase
   end

   for (genvar gi = 0; gi < 4; gi++) begin : g_merge
      assign merged_word[8*gi +: 8] = lane_mask[gi] ? wdata_rep[8*gi +: 8]
                                                    : rd_word_reg[8*gi +: 8];
   end

   always_comb begin
      access_err = 1'b0;
      if ((f3_reg == F3_H || f3_reg == F3_HU) && addr_reg[0])
         access_err = 1'b1;
      if (f3_reg == F3_W && addr_reg[1:0] != 2'b00)
         access_err = 1'b1;
      if ({2'b00, addr_reg[31:2]} >= 32'(DEPTH_WORDS))
         access_err = 1'b1;
      if (f3_reg == 3'b011 || f3_reg == 3'b110 || f3_reg == 3'b111)
         access_err = 1'b1;
      if (we_reg && (f3_reg == F3_BU || f3_reg == F3_HU))
         access_err = 1'b1;
   end

   // Reset sampled at the ACCESS edge suppresses the write.
   always_ff @(posedge clk) begin
      if (!rst && state_reg == ST_ACCESS && we_reg && !access_err)
         mem[addr_reg[IDX_W+1:2]] <= merged_word;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= ST_IDLE;
         cnt_reg       <= '0;
         we_reg        <= 1'b0;
         addr_reg      <= '0;
         wdata_reg     <= '0;
         f3_reg        <= '0;
         req_ready_reg <= 1'b1;
         rsp_valid_reg <= 1'b0;
         rsp_rdata_reg <= '0;
         rsp_err_reg   <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (bus.req_valid && req_ready_reg) begin
                  we_reg        <= bus.req_we;
                  addr_reg      <= bus.req_addr;
                  wdata_reg     <= bus.req_wdata;
                  f3_reg        <= bus.req_funct3;
                  req_ready_reg <= 1'b0;
                  cnt_reg       <= WAIT_INIT;
                  state_reg     <= (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;
               end
            end
            ST_WAIT: begin
               if (cnt_reg == 4'd0)
                  state_reg <= ST_ACCESS;
               else
                  cnt_reg <= cnt_reg - 4'd1;
            end
            ST_ACCESS: begin
               rsp_rdata_reg <= (access_err || we_reg) ? 32'd0 : load_data;
               rsp_err_reg   <= access_err;
               rsp_valid_reg <= 1'b1;
               state_reg     <= ST_RESP;
            end
            ST_RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_reg <= 1'b0;
                  rsp_rdata_reg <= '0;
                  rsp_err_reg   <= 1'b0;
                  req_ready_reg <= 1'b1;
                  state_reg     <= ST_IDLE;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

endmodule
